// File: rtl/sdram_arbiter.sv
// sdram_arbiter: fixed-priority slot arbiter between downloader FIFO, eraser and Z80 for the SDRAM controller.
// Latency: pushed byte is eligible at the first slot_ena at least one cycle later; outputs update on the slot_ena cycle edge.
// Backpressure: downloader bytes are buffered in a small FIFO; when full a byte is dropped (sticky dl_overflow), the CPU sees cpu_stall.
//
// Optional feature macro: SDRAM_ARB_STATS_EN adds the dl_count[15:0] output (FIFO pop counter).

// Small generic FIFO: combinational read of the head entry, write/read on the clock edge.
// Latency: one cycle from push to visibility on empty/level.
// Backpressure: caller must only assert i_push when not full or when popping in the same cycle.
module sdram_arb_fifo #(
  parameter int W  = 33,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_wdat,
  output logic [W-1:0]  o_rdat,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_level
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  // Storage write; no reset needed since occupancy tracks valid entries.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdat;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdat  = r_mem[r_rd_ptr];
  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_level = r_level;

endmodule

// sdram_arbiter top.
// Latency: decision and sdram_* outputs registered on slot_ena cycles only, held between slots.
// Backpressure: downloader buffered (drop + sticky flag when full); cpu_stall tells the Z80 it does not own the slot.
module sdram_arbiter #(
  parameter int         FIFO_DEPTH_LOG2 = 2,
  parameter logic [8:0] CPU_ADDR_HI     = 9'd0
) (
  input  logic                     sys_clock,
  input  logic                     reset,
  input  logic                     slot_ena,
  input  logic                     dl_wr,
  input  logic [24:0]              dl_addr,
  input  logic [7:0]               dl_data,
  input  logic                     er_busy,
  input  logic                     er_wr,
  input  logic [24:0]              er_addr,
  input  logic [7:0]               er_data,
  input  logic [15:0]              cpu_addr,
  input  logic [7:0]               cpu_dout,
  input  logic                     cpu_rd,
  input  logic                     cpu_wr,
  output logic [24:0]              sdram_addr,
  output logic [7:0]               sdram_din,
  output logic                     sdram_wr,
  output logic                     sdram_rd,
  output logic                     cpu_stall,
  output logic                     dl_overflow,
`ifdef SDRAM_ARB_STATS_EN
  output logic [15:0]              dl_count,
`endif
  output logic [FIFO_DEPTH_LOG2:0] fifo_level
);

  typedef enum logic [1:0] {
    OWN_CPU = 2'd0,
    OWN_DL  = 2'd1,
    OWN_ER  = 2'd2
  } own_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } dl_entry_t;

  own_t        r_state;
  logic [24:0] r_addr;
  logic [7:0]  r_din;
  logic        r_wr;
  logic        r_rd;
  logic        r_overflow;

  dl_entry_t                w_head;
  dl_entry_t                w_wdat;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_push;
  logic [FIFO_DEPTH_LOG2:0] w_level;

  // A slot always drains the FIFO first, so a pop happens on every slot with data queued.
  assign w_pop  = slot_ena & ~w_empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push = dl_wr & (~w_full | w_pop);
  assign w_wdat = '{addr: dl_addr, data: dl_data};

  sdram_arb_fifo #(
    .W  ($bits(dl_entry_t)),
    .AW (FIFO_DEPTH_LOG2)
  ) u_dl_fifo (
    .clk     (sys_clock),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdat  (w_wdat),
    .o_rdat  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (w_level)
  );

  // Sticky overflow flag: set when a byte is dropped, cleared only by reset.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (dl_wr && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  // Slot ownership FSM with registered SDRAM command outputs, updated only on slot_ena.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_state <= OWN_CPU;
      r_addr  <= '0;
      r_din   <= '0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
    end else if (slot_ena) begin
      if (!w_empty) begin
        r_state <= OWN_DL;
        r_addr  <= w_head.addr;
        r_din   <= w_head.data;
        r_wr    <= 1'b1;
        r_rd    <= 1'b1;
      end else if (er_busy) begin
        r_state <= OWN_ER;
        r_addr  <= er_addr;
        r_din   <= er_data;
        r_wr    <= er_wr;
        r_rd    <= 1'b1;
      end else begin
        r_state <= OWN_CPU;
        r_addr  <= {CPU_ADDR_HI, cpu_addr};
        r_din   <= cpu_dout;
        r_wr    <= cpu_wr;
        r_rd    <= cpu_rd;
      end
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  logic [15:0] r_dl_count;

  // Count committed downloader bytes; wraps naturally at 16 bits.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_dl_count <= '0;
    end else if (w_pop) begin
      r_dl_count <= r_dl_count + 16'd1;
    end
  end

  assign dl_count = r_dl_count;
`endif

  assign sdram_addr  = r_addr;
  assign sdram_din   = r_din;
  assign sdram_wr    = r_wr;
  assign sdram_rd    = r_rd;
  assign dl_overflow = r_overflow;
  assign fifo_level  = w_level;
  // Held low during reset so every output reads zero while reset is asserted.
  assign cpu_stall   = ~reset & ((r_state != OWN_CPU) | ~w_empty | er_busy);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: reset, CPU pass-through, FIFO drain order,
// overflow/full-with-pop boundaries, eraser priority and same-cycle push/slot.
module tb_sdram_arbiter;

  logic        sys_clock;
  logic        reset;
  logic        slot_ena;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        er_busy;
  logic        er_wr;
  logic [24:0] er_addr;
  logic [7:0]  er_data;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_din;
  logic        sdram_wr;
  logic        sdram_rd;
  logic        cpu_stall;
  logic        dl_overflow;
  logic [2:0]  fifo_level;
`ifdef SDRAM_ARB_STATS_EN
  logic [15:0] dl_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sdram_arbiter #(
    .FIFO_DEPTH_LOG2 (2),
    .CPU_ADDR_HI     (9'd0)
  ) dut (
    .sys_clock   (sys_clock),
    .reset       (reset),
    .slot_ena    (slot_ena),
    .dl_wr       (dl_wr),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .er_busy     (er_busy),
    .er_wr       (er_wr),
    .er_addr     (er_addr),
    .er_data     (er_data),
    .cpu_addr    (cpu_addr),
    .cpu_dout    (cpu_dout),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .sdram_addr  (sdram_addr),
    .sdram_din   (sdram_din),
    .sdram_wr    (sdram_wr),
    .sdram_rd    (sdram_rd),
    .cpu_stall   (cpu_stall),
    .dl_overflow (dl_overflow),
`ifdef SDRAM_ARB_STATS_EN
    .dl_count    (dl_count),
`endif
    .fifo_level  (fifo_level)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One slot: pulse slot_ena for a single cycle.
  task automatic slot();
    slot_ena = 1'b1;
    tick();
    slot_ena = 1'b0;
  endtask

  task automatic push(input logic [24:0] a, input logic [7:0] d);
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    tick();
    dl_wr   = 1'b0;
  endtask

  task automatic chk_cmd(input string tag, input logic [24:0] a, input logic [7:0] d,
                         input logic w, input logic r);
    chk({tag, "_addr"}, 32'(sdram_addr), 32'(a));
    chk({tag, "_din"},  32'(sdram_din),  32'(d));
    chk({tag, "_wr"},   32'(sdram_wr),   32'(w));
    chk({tag, "_rd"},   32'(sdram_rd),   32'(r));
  endtask

  initial begin
    // 1: reset held 3 cycles with random inputs
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slot_ena = 1'($urandom);
      dl_wr    = 1'($urandom);
      dl_addr  = 25'($urandom);
      dl_data  = 8'($urandom);
      er_busy  = 1'($urandom);
      er_wr    = 1'($urandom);
      er_addr  = 25'($urandom);
      er_data  = 8'($urandom);
      cpu_addr = 16'($urandom);
      cpu_dout = 8'($urandom);
      cpu_rd   = 1'($urandom);
      cpu_wr   = 1'($urandom);
      tick();
    end
    chk_cmd("rst", 25'h0, 8'h0, 1'b0, 1'b0);
    chk("rst_stall", 32'(cpu_stall),   32'd0);
    chk("rst_ovf",   32'(dl_overflow), 32'd0);
    chk("rst_level", 32'(fifo_level),  32'd0);

    reset = 1'b0; slot_ena = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    er_busy = 1'b0; er_wr = 1'b0; er_addr = '0; er_data = '0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_dout = '0;
    tick();

    // 2: CPU write through an idle arbiter
    cpu_wr = 1'b1; cpu_addr = 16'h8241; cpu_dout = 8'h5A;
    slot();
    chk_cmd("cpu_wr", 25'h0008241, 8'h5A, 1'b1, 1'b0);
    chk("cpu_stall", 32'(cpu_stall), 32'd0);
    // Outputs must hold between slots even if the CPU inputs move.
    cpu_addr = 16'h1111;
    tick();
    chk("cpu_hold", 32'(sdram_addr), 32'h0008241);

    cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'h0777; cpu_dout = 8'h77;

    // 3: four bytes drained in order on consecutive slots
    for (int i = 0; i < 4; i++) push(25'(i), 8'(8'h10 + i));
    chk("q4_level", 32'(fifo_level), 32'd4);
    chk("q4_stall", 32'(cpu_stall),  32'd1);
    for (int k = 0; k < 4; k++) begin
      slot();
      chk_cmd($sformatf("drain%0d", k), 25'(k), 8'(8'h10 + k), 1'b1, 1'b1);
      chk($sformatf("drain%0d_lvl", k), 32'(fifo_level), 32'(3 - k));
      repeat (3) tick();
    end
    chk("dl_own_stall", 32'(cpu_stall), 32'd1);
    slot();
    chk_cmd("cpu_rd", 25'h0000777, 8'h77, 1'b0, 1'b1);
    chk("cpu_rd_stall", 32'(cpu_stall),   32'd0);
    chk("q4_ovf",       32'(dl_overflow), 32'd0);

    // 4: overflow with six bytes, then push-while-full-with-pop
    for (int i = 0; i < 6; i++) push(25'(25'h100 + i), 8'(8'h20 + i));
    chk("ovf_level", 32'(fifo_level),  32'd4);
    chk("ovf_flag",  32'(dl_overflow), 32'd1);
    dl_wr = 1'b1; dl_addr = 25'h1FF; dl_data = 8'h99; slot_ena = 1'b1;
    tick();
    dl_wr = 1'b0; slot_ena = 1'b0;
    chk_cmd("fullpop", 25'h100, 8'h20, 1'b1, 1'b1);
    chk("fullpop_lvl", 32'(fifo_level), 32'd4);
    slot(); chk_cmd("ovf_d1", 25'h101, 8'h21, 1'b1, 1'b1);
    slot(); chk_cmd("ovf_d2", 25'h102, 8'h22, 1'b1, 1'b1);
    slot(); chk_cmd("ovf_d3", 25'h103, 8'h23, 1'b1, 1'b1);
    slot(); chk_cmd("ovf_d4", 25'h1FF, 8'h99, 1'b1, 1'b1);
    slot(); chk_cmd("ovf_cpu", 25'h0000777, 8'h77, 1'b0, 1'b1);
    chk("ovf_sticky", 32'(dl_overflow), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ovf_cleared", 32'(dl_overflow), 32'd0);
    chk("rst2_addr",   32'(sdram_addr),  32'd0);

    // 5: FIFO entry beats an active eraser, eraser gets the next slot
    push(25'h1ABCDEF, 8'hC3);
    er_busy = 1'b1; er_wr = 1'b0; er_addr = 25'h0123456; er_data = 8'hE5;
    chk("er_pre_stall", 32'(cpu_stall), 32'd1);
    slot();
    chk_cmd("er_dl", 25'h1ABCDEF, 8'hC3, 1'b1, 1'b1);
    slot();
    chk_cmd("er_own", 25'h0123456, 8'hE5, 1'b0, 1'b1);
    chk("er_stall", 32'(cpu_stall), 32'd1);
    er_busy = 1'b0;
    chk("er_state_stall", 32'(cpu_stall), 32'd1);
    slot();
    chk_cmd("er_done_cpu", 25'h0000777, 8'h77, 1'b0, 1'b1);
    chk("er_done_stall", 32'(cpu_stall), 32'd0);

    // 6: push and slot in the same cycle with an empty FIFO
    dl_wr = 1'b1; dl_addr = 25'h42; dl_data = 8'h42; slot_ena = 1'b1;
    tick();
    dl_wr = 1'b0; slot_ena = 1'b0;
    chk_cmd("same_cpu", 25'h0000777, 8'h77, 1'b0, 1'b1);
    chk("same_level", 32'(fifo_level), 32'd1);
    chk("same_stall", 32'(cpu_stall),  32'd1);
    slot();
    chk_cmd("same_commit", 25'h42, 8'h42, 1'b1, 1'b1);
    chk("same_level0", 32'(fifo_level), 32'd0);

    // One more byte so three commits have happened since the last reset.
    push(25'h55, 8'h55);
    slot();
    chk_cmd("third_commit", 25'h55, 8'h55, 1'b1, 1'b1);
`ifdef SDRAM_ARB_STATS_EN
    chk("stats_cnt3", 32'(dl_count), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("stats_rst", 32'(dl_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
